// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side port bundle of the async FIFO read controller.
//   master : read-domain user; drives rd_en and the synchronised Gray write pointer w2r_ptr.
//   slave  : fifo_rd_ctrl; drives rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level
//            and rd_underflow when FIFO_RD_UNDERFLOW_EN is defined.
interface fifo_rd_ctrl_if #(parameter int ASIZE = 4);
  logic             rd_en;
  logic [ASIZE:0]   w2r_ptr;
  logic [ASIZE-1:0] rd_addr;
  logic [ASIZE:0]   rd_ptr;
  logic             rd_empty;
  logic             rd_almost_empty;
  logic [ASIZE:0]   rd_level;
`ifdef FIFO_RD_UNDERFLOW_EN
  logic             rd_underflow;
  modport master (output rd_en, w2r_ptr,
                  input  rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level, rd_underflow);
  modport slave  (input  rd_en, w2r_ptr,
                  output rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level, rd_underflow);
`else
  modport master (output rd_en, w2r_ptr,
                  input  rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level);
  modport slave  (input  rd_en, w2r_ptr,
                  output rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level);
`endif
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side controller (read pointer, RAM address, empty/level status).
//   rd_clk, rd_rst (async, active-high) : read-domain clock and reset
//   bus (slave) : rd_en, w2r_ptr in; rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level out
//   Optional macro FIFO_RD_UNDERFLOW_EN adds the sticky rd_underflow output.
module fifo_rd_ctrl #(
  parameter int ASIZE     = 4,
  parameter int AE_THRESH = 2
) (
  input logic            rd_clk,
  input logic            rd_rst,
  fifo_rd_ctrl_if.slave  bus
);
  localparam logic [ASIZE:0] AE = AE_THRESH[ASIZE:0];
  logic [ASIZE:0] rbin_q, rbin_d, rgray_q, rgray_d, lvl_q, lvl_d, wbin_s;
  logic           empty_q, empty_d, ae_q, ae_d, rd_inc;
  // Gray-to-binary: bit g is the XOR of all Gray bits at or above g.
  for (genvar g = 0; g <= ASIZE; g++) begin : g2b
    assign wbin_s[g] = ^(bus.w2r_ptr >> g);
  end
  always_comb begin
    rd_inc  = bus.rd_en & ~empty_q;
    rbin_d  = rbin_q + {{ASIZE{1'b0}}, rd_inc};
    rgray_d = rbin_d ^ (rbin_d >> 1);
    // Status looks at the post-read pointer so the last read sets empty on the same edge.
    empty_d = rgray_d == bus.w2r_ptr;
    lvl_d   = wbin_s - rbin_d;
    ae_d    = lvl_d <= AE;
  end
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      lvl_q   <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      lvl_q   <= lvl_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
    end
`ifdef FIFO_RD_UNDERFLOW_EN
  logic uf_q;
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) uf_q <= 1'b0;
    else        uf_q <= uf_q | (bus.rd_en & empty_q);
  assign bus.rd_underflow = uf_q;
`endif
  assign bus.rd_addr         = rbin_q[ASIZE-1:0];
  assign bus.rd_ptr          = rgray_q;
  assign bus.rd_empty        = empty_q;
  assign bus.rd_almost_empty = ae_q;
  assign bus.rd_level        = lvl_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed + randomized bench for fifo_rd_ctrl against a word-count model.
module tb_fifo_rd_ctrl;
  localparam int ASIZE = 4;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << ASIZE;
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b0;
  int   tests = 0, fails = 0;
  int   wcnt = 0, rcnt = 0, lvl = 0;
  logic m_uf = 1'b0;
  logic [ASIZE:0] prev_ptr = '0;
  fifo_rd_ctrl_if #(.ASIZE(ASIZE)) bus ();
  fifo_rd_ctrl #(.ASIZE(ASIZE), .AE_THRESH(AE)) dut (.rd_clk(rd_clk), .rd_rst(rd_rst), .bus(bus));
  always #5 rd_clk = ~rd_clk;
  function automatic logic [ASIZE:0] gray(input int n);
    logic [ASIZE:0] b;
    b = (ASIZE+1)'(n);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("rd_addr", 32'(bus.rd_addr), 32'(rcnt % DEPTH));
    chk("rd_ptr", 32'(bus.rd_ptr), 32'(gray(rcnt)));
    chk("rd_empty", 32'(bus.rd_empty), 32'(lvl == 0));
    chk("rd_almost_empty", 32'(bus.rd_almost_empty), 32'(lvl <= AE));
    chk("rd_level", 32'(bus.rd_level), 32'(lvl));
    chk("ptr_one_bit_step", 32'($countones(prev_ptr ^ bus.rd_ptr) <= 1), 32'd1);
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("rd_underflow", 32'(bus.rd_underflow), 32'(m_uf));
`endif
    prev_ptr = bus.rd_ptr;
  endtask
  // One rd_clk cycle: present inputs, let the edge happen, advance the model, check 1 after.
  task automatic step(input logic en, input logic wr);
    bus.rd_en = en;
    if (wr) begin
      wcnt++;
      bus.w2r_ptr = gray(wcnt);
    end
    @(posedge rd_clk);
    if (en && lvl == 0) m_uf = 1'b1;
    if (en && lvl != 0) rcnt++;
    lvl = wcnt - rcnt;
    #1;
    check_all();
  endtask
  task automatic do_reset();
    @(posedge rd_clk);
    #3;
    rd_rst = 1'b1;
    bus.rd_en = 1'b0;
    bus.w2r_ptr = '0;
    wcnt = 0; rcnt = 0; lvl = 0; m_uf = 1'b0; prev_ptr = '0;
    #1;
    check_all();
    @(negedge rd_clk);
    rd_rst = 1'b0;
    @(posedge rd_clk);
    #1;
  endtask
  task automatic set_w(input int n);
    wcnt = n;
    bus.w2r_ptr = gray(n);
  endtask
  initial begin
    bus.rd_en = 1'b0;
    bus.w2r_ptr = '0;
    do_reset();
    set_w(3);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    do_reset();
    set_w(3);
    step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("simul_level", 32'(bus.rd_level), 32'd1);
    chk("simul_empty", 32'(bus.rd_empty), 32'd0);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 99) < 50), 1'((wcnt - rcnt) < DEPTH && $urandom_range(0, 99) < 55));
    while (wcnt - rcnt < DEPTH) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("full_level", 32'(bus.rd_level), 32'(DEPTH));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 99) < 60), 1'((wcnt - rcnt) < DEPTH && $urandom_range(0, 99) < 45));
    set_w(wcnt);
    repeat (5) step(1'b0, 1'b1);
    bus.rd_en = 1'b1;
    #2;
    rd_rst = 1'b1;
    wcnt = 0; rcnt = 0; lvl = 0; m_uf = 1'b0; prev_ptr = '0;
    bus.w2r_ptr = '0;
    bus.rd_en = 1'b0;
    #1;
    check_all();
    @(negedge rd_clk);
    rd_rst = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
